mult4u_sweep_checker: RTL

// - Sequential exhaustive self-test stage wrapped around a combinational 4x4 unsigned multiplier.
// - Upstream role: drives every operand pair A,B in 0..15 into the multiplier.
// - Downstream role: samples the 8-bit product O, compares it against a golden A*B and logs mismatches.
// - Purpose: measure the fault behaviour of evolved multiplier netlists on silicon/FPGA.

---
 rtl/mult4u_pkg.sv | 8 +
 rtl/mult4u_golden.sv | 11 +
 rtl/mult4u_sweep_checker.sv | 80 ++++++++
 3 files changed

// File: rtl/mult4u_pkg.sv
// mult4u_pkg: shared constants and state type for the 4x4 multiplier sweep checker.
package mult4u_pkg;
  localparam int AW = 4;
  localparam int PW = 2 * AW;
  localparam int NV = 2 ** (2 * AW);
  localparam int SCW = 4;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
endpackage

// File: rtl/mult4u_golden.sv
// mult4u_golden: behavioural unsigned multiply used as the reference product.
// Kept in its own module so fault injection can exclude it.
module mult4u_golden import mult4u_pkg::*; #(
  parameter int W = AW
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
endmodule

// File: rtl/mult4u_sweep_checker.sv
// mult4u_sweep_checker: drives every operand pair into an external multiplier,
// compares its product with a golden model and logs the mismatches.
module mult4u_sweep_checker import mult4u_pkg::*; #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [AW-1:0]   dut_a,
  output logic [AW-1:0]   dut_b,
  input  logic [PW-1:0]   dut_p,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [2*AW:0]   err_count,
  output logic            first_fail_vld,
  output logic [2*AW-1:0] first_fail_vec,
  output logic [PW-1:0]   bit_err_mask
);
  state_t state;
  logic [2*AW-1:0] vec;
  logic [SCW-1:0] settle;
  logic [PW-1:0] golden, diff;
  mult4u_golden #(.W(AW)) u_golden (.a(dut_a), .b(dut_b), .p(golden));
  // vec is the operand register itself, so the operands are registered outputs
  assign {dut_a, dut_b} = vec;
  assign diff = dut_p ^ golden;
  assign busy = (state == DRIVE) || (state == CHECK);
  assign pass = done && (err_count == '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vec <= '0;
      settle <= '0;
      done <= 1'b0;
      err_count <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
      bit_err_mask <= '0;
    end else if (abort && state != IDLE) begin
      // abort wins over start and over the CHECK logging of this cycle
      state <= IDLE;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= DRIVE;
          vec <= '0;
          settle <= SCW'(SETTLE_CYCLES - 1);
          done <= 1'b0;
          err_count <= '0;
          first_fail_vld <= 1'b0;
          first_fail_vec <= '0;
          bit_err_mask <= '0;
        end
        DRIVE: if (settle == '0) state <= CHECK; else settle <= settle - 1'b1;
        CHECK: begin
          if (diff != '0) begin
            err_count <= err_count + 1'b1;
            bit_err_mask <= bit_err_mask | diff;
            if (!first_fail_vld) begin
              first_fail_vld <= 1'b1;
              first_fail_vec <= vec;
            end
          end
          if (vec == (2*AW)'(NV - 1)) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            vec <= vec + 1'b1;
            settle <= SCW'(SETTLE_CYCLES - 1);
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
